// File: rtl/normalization_controller.sv
// Streams a job of accumulator rows through the Normalization datapath into a 2-entry output FIFO.
// Reads are credit-limited so the FIFO never overflows; Done pulses after the last row leaves.
module normalization_controller #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int SA_LENGTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic                                 Start,
    input  logic [ADDR_WIDTH-1:0]                BaseAddr,
    input  logic [ADDR_WIDTH:0]                  NumRows,
    input  logic [7:0]                           ShiftIn,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 AccRdEn,
    output logic [ADDR_WIDTH-1:0]                AccRdAddr,
    output logic [7:0]                           ShiftAmmount,
    input  logic signed [SA_LENGTH*OUT_WIDTH-1:0] NormOut,
    output logic signed [SA_LENGTH*OUT_WIDTH-1:0] OutData,
    output logic                                 OutValid,
    input  logic                                 OutReady,
    output logic                                 OutLast
);

    localparam int ROW_W = SA_LENGTH * OUT_WIDTH;

    if (IN_WIDTH < OUT_WIDTH) begin : g_width_check
        $error("IN_WIDTH must be at least OUT_WIDTH");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   reads_left_q, reads_left_d;
    logic [7:0]            shift_q, shift_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [ROW_W-1:0]      data_mem_q [2];
    logic [ROW_W-1:0]      data_mem_d [2];
    logic                  last_mem_q [2];
    logic                  last_mem_d [2];

    logic       start_ok;
    logic       rd_en;
    logic       last_read;
    logic       out_valid;
    logic       head_last;
    logic       push;
    logic       pop;
    logic [2:0] occ;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        reads_left_d    = reads_left_q;
        shift_d         = shift_q;
        done_d          = 1'b0;
        count_d         = count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        data_mem_d      = data_mem_q;
        last_mem_d      = last_mem_q;

        out_valid = (count_q != 2'd0);
        head_last = last_mem_q[rd_ptr_q];
        pop       = out_valid && OutReady;
        push      = inflight_q;

        // Occupancy counts the row in flight; a same-cycle pop frees one slot.
        occ      = 3'(count_q) + 3'(inflight_q);
        start_ok = Start && (state_q == ST_IDLE) && !done_q;
        rd_en    = (state_q == ST_RUN) && ((occ - 3'(pop)) < 3'd2);
        last_read = rd_en && (reads_left_q == (ADDR_WIDTH+1)'(1));

        inflight_d      = rd_en;
        inflight_last_d = last_read;

        if (start_ok) begin
            shift_d      = ShiftIn;
            rd_addr_d    = BaseAddr;
            reads_left_d = NumRows;
            if (NumRows == '0) begin
                done_d = 1'b1;
            end
        end

        if (rd_en) begin
            rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
            reads_left_d = reads_left_q - (ADDR_WIDTH+1)'(1);
        end

        unique case (state_q)
            ST_IDLE:  if (start_ok && NumRows != '0) state_d = ST_RUN;
            ST_RUN:   if (last_read) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && head_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (pop && head_last) begin
            done_d = 1'b1;
        end

        // On a full FIFO the write slot equals the head being popped, so order is preserved.
        if (push) begin
            data_mem_d[wr_ptr_q] = NormOut;
            last_mem_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q         <= ST_IDLE;
            rd_addr_q       <= '0;
            reads_left_q    <= '0;
            shift_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            count_q         <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            reads_left_q    <= reads_left_d;
            shift_q         <= shift_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; every output derived from it is gated by occupancy.
    always_ff @(posedge Clk) begin
        data_mem_q <= data_mem_d;
        last_mem_q <= last_mem_d;
    end

    assign Busy         = (state_q != ST_IDLE) || done_q;
    assign Done         = done_q;
    assign AccRdEn      = rd_en;
    assign AccRdAddr    = rd_addr_q;
    assign ShiftAmmount = shift_q;
    assign OutValid     = out_valid;
    assign OutLast      = out_valid && head_last;
    assign OutData      = out_valid ? data_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_normalization_controller.sv
// Directed bench for normalization_controller with a behavioural accumulator buffer and
// Normalization stage (arithmetic right shift, saturate to signed 8 bits) per lane.
module tb_normalization_controller;

    localparam int SA = 4;
    localparam int OW = 8;
    localparam int AW = 10;
    localparam int RW = SA * OW;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic                 Start;
    logic [AW-1:0]        BaseAddr;
    logic [AW:0]          NumRows;
    logic [7:0]           ShiftIn;
    logic                 Busy, Done, AccRdEn, OutValid, OutLast, OutReady;
    logic [AW-1:0]        AccRdAddr;
    logic [7:0]           ShiftAmmount;
    logic signed [RW-1:0] NormOut;
    logic signed [RW-1:0] OutData;

    normalization_controller #(
        .IN_WIDTH(32), .OUT_WIDTH(OW), .SA_LENGTH(SA), .ADDR_WIDTH(AW)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .NumRows(NumRows),
        .ShiftIn(ShiftIn), .Busy(Busy), .Done(Done), .AccRdEn(AccRdEn), .AccRdAddr(AccRdAddr),
        .ShiftAmmount(ShiftAmmount), .NormOut(NormOut), .OutData(OutData), .OutValid(OutValid),
        .OutReady(OutReady), .OutLast(OutLast)
    );

    always #5 Clk = ~Clk;

    logic signed [31:0] acc_buf [1024][SA];
    logic signed [31:0] rd_row [SA];

    always @(posedge Clk) begin
        if (AccRdEn) begin
            for (int i = 0; i < SA; i++) rd_row[i] <= acc_buf[AccRdAddr][i];
        end
    end

    function automatic logic [7:0] norm_lane(input logic signed [31:0] v, input logic [7:0] sh);
        logic signed [31:0] s;
        s = v >>> sh;
        if (s > 127) return 8'h7f;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    always_comb begin
        NormOut = '0;
        for (int i = 0; i < SA; i++) NormOut[i*OW +: OW] = norm_lane(rd_row[i], ShiftAmmount);
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Event logs collected at the falling edge, away from the active clock edge.
    logic [AW-1:0] rd_addr_log[$];
    int            rd_cyc_log[$];
    logic [RW-1:0] pop_data_log[$];
    logic          pop_last_log[$];
    int            pop_cyc_log[$];
    int            done_cyc_log[$];
    int issued, popped, max_out, valid_cnt, busy_cnt, busy_first, busy_last, stall_viol;
    logic          prev_stall;
    logic [RW-1:0] prev_data;
    logic          prev_last;

    always @(negedge Clk) begin
        if ((issued - popped) > max_out) max_out = issued - popped;
        if (AccRdEn) begin
            rd_addr_log.push_back(AccRdAddr);
            rd_cyc_log.push_back(cyc);
            issued++;
        end
        if (OutValid) valid_cnt++;
        if (OutValid && OutReady) begin
            pop_data_log.push_back(OutData);
            pop_last_log.push_back(OutLast);
            pop_cyc_log.push_back(cyc);
            popped++;
        end
        if (Done) done_cyc_log.push_back(cyc);
        if (Busy) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
        if (prev_stall && (!OutValid || OutData !== prev_data || OutLast !== prev_last)) stall_viol++;
        prev_stall = OutValid && !OutReady;
        prev_data  = OutData;
        prev_last  = OutLast;
    end

    task automatic clear_logs();
        rd_addr_log.delete(); rd_cyc_log.delete(); pop_data_log.delete();
        pop_last_log.delete(); pop_cyc_log.delete(); done_cyc_log.delete();
        issued = 0; popped = 0; max_out = 0; valid_cnt = 0; busy_cnt = 0;
        busy_first = -1; busy_last = -1; stall_viol = 0; prev_stall = 1'b0;
    endtask

    task automatic set_row(input int a, input int l0, input int l1, input int l2, input int l3);
        acc_buf[a][0] = l0; acc_buf[a][1] = l1; acc_buf[a][2] = l2; acc_buf[a][3] = l3;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [AW:0] n, input logic [7:0] sh,
                             output int c0);
        @(posedge Clk); #1;
        clear_logs();
        Start = 1'b1; BaseAddr = base; NumRows = n; ShiftIn = sh;
        c0 = cyc;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] pat, input int c0, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            OutReady = pat[(cyc - c0) % 4];
            @(posedge Clk); #1;
            if (done_cyc_log.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
        OutReady = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; BaseAddr = '0; NumRows = '0; ShiftIn = '0; OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", Done); end
        vectors++; if (AccRdEn !== 1'b0) begin miscompares++; $display("FAIL reset_rden: got %b want 0", AccRdEn); end
        vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", OutValid); end
        vectors++; if (OutLast !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", OutLast); end
        vectors++; if (AccRdAddr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", AccRdAddr); end
        vectors++; if (ShiftAmmount !== 8'd0) begin miscompares++; $display("FAIL reset_shift: got %0d want 0", ShiftAmmount); end
        vectors++; if (OutData !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", OutData); end
        Rst = 1'b0;
    endtask

    task automatic test_single_row();
        int c0; bit ok;
        set_row(5, 25600, -768, 512, 255);
        start_job(10'd5, 11'd1, 8'd8, c0);
        vectors++; if (ShiftAmmount !== 8'd8) begin miscompares++; $display("FAIL single_shift: got %0d want 8", ShiftAmmount); end
        wait_done(4'b1111, c0, 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout: got no Done want Done"); end
        vectors++; if (rd_addr_log.size() != 1) begin miscompares++; $display("FAIL single_rd_count: got %0d want 1", rd_addr_log.size()); end
        else begin
            vectors++; if (rd_addr_log[0] !== 10'd5) begin miscompares++; $display("FAIL single_rd_addr: got %0d want 5", rd_addr_log[0]); end
            vectors++; if (rd_cyc_log[0] != c0 + 1) begin miscompares++; $display("FAIL single_rd_cycle: got %0d want %0d", rd_cyc_log[0], c0 + 1); end
        end
        vectors++; if (pop_data_log.size() != 1) begin miscompares++; $display("FAIL single_pop_count: got %0d want 1", pop_data_log.size()); end
        else begin
            vectors++; if (pop_data_log[0] !== 32'h0002FD64) begin miscompares++; $display("FAIL single_data: got %h want 0002fd64", pop_data_log[0]); end
            vectors++; if (pop_last_log[0] !== 1'b1) begin miscompares++; $display("FAIL single_last: got %b want 1", pop_last_log[0]); end
            vectors++; if (pop_cyc_log[0] != c0 + 3) begin miscompares++; $display("FAIL single_pop_cycle: got %0d want %0d", pop_cyc_log[0], c0 + 3); end
        end
        vectors++; if (done_cyc_log.size() != 1 || done_cyc_log[0] != c0 + 4) begin miscompares++; $display("FAIL single_done_cycle: got %0d pulses want one at %0d", done_cyc_log.size(), c0 + 4); end
        vectors++; if (busy_first != c0 + 1 || busy_last != c0 + 4 || busy_cnt != 4) begin miscompares++; $display("FAIL single_busy: got %0d..%0d (%0d) want %0d..%0d (4)", busy_first, busy_last, busy_cnt, c0 + 1, c0 + 4); end
    endtask

    task automatic test_saturation();
        int c0; bit ok;
        logic [RW-1:0] exp_rows [2];
        exp_rows[0] = 32'hFF7F7F7F;
        exp_rows[1] = 32'h00808080;
        set_row(40, 1000000, 32767, 32768, -1);
        set_row(41, -40000, -32768, -32769, 255);
        start_job(10'd40, 11'd2, 8'd8, c0);
        wait_done(4'b1111, c0, 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sat_timeout: got no Done want Done"); end
        vectors++; if (pop_data_log.size() != 2) begin miscompares++; $display("FAIL sat_pop_count: got %0d want 2", pop_data_log.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                vectors++; if (pop_data_log[i] !== exp_rows[i]) begin miscompares++; $display("FAIL sat_data[%0d]: got %h want %h", i, pop_data_log[i], exp_rows[i]); end
                vectors++; if (pop_last_log[i] !== (i == 1)) begin miscompares++; $display("FAIL sat_last[%0d]: got %b want %b", i, pop_last_log[i], i == 1); end
            end
        end
    endtask

    task automatic test_addr_wrap();
        int c0; bit ok;
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 10'd1022; exp_addr[1] = 10'd1023; exp_addr[2] = 10'd0; exp_addr[3] = 10'd1;
        for (int i = 0; i < 4; i++) set_row(int'(exp_addr[i]), 10 + i, 0, 0, 0);
        start_job(10'd1022, 11'd4, 8'd0, c0);
        wait_done(4'b1111, c0, 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got no Done want Done"); end
        vectors++; if (rd_addr_log.size() != 4) begin miscompares++; $display("FAIL wrap_rd_count: got %0d want 4", rd_addr_log.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (rd_addr_log[i] !== exp_addr[i] || rd_cyc_log[i] != c0 + 1 + i) begin miscompares++; $display("FAIL wrap_rd[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d", i, rd_addr_log[i], rd_cyc_log[i], exp_addr[i], c0 + 1 + i); end
            end
        end
        vectors++; if (pop_data_log.size() != 4) begin miscompares++; $display("FAIL wrap_pop_count: got %0d want 4", pop_data_log.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (pop_data_log[i] !== RW'(10 + i) || pop_cyc_log[i] != c0 + 3 + i || pop_last_log[i] !== (i == 3)) begin miscompares++; $display("FAIL wrap_pop[%0d]: got %h cyc %0d last %b want %h cyc %0d last %b", i, pop_data_log[i], pop_cyc_log[i], pop_last_log[i], RW'(10 + i), c0 + 3 + i, i == 3); end
            end
        end
        vectors++; if (done_cyc_log.size() != 1 || done_cyc_log[0] != c0 + 7) begin miscompares++; $display("FAIL wrap_done: got %0d pulses want one at %0d", done_cyc_log.size(), c0 + 7); end
    endtask

    task automatic test_backpressure();
        int c0; bit ok;
        logic [RW-1:0] exp_row;
        for (int i = 0; i < 6; i++) set_row(100 + i, 20 + i, 0, 7, 0);
        start_job(10'd100, 11'd6, 8'd0, c0);
        wait_done(4'b1001, c0, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got no Done want Done"); end
        vectors++; if (pop_data_log.size() != 6) begin miscompares++; $display("FAIL bp_pop_count: got %0d want 6", pop_data_log.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                exp_row = {8'h00, 8'h07, 8'h00, 8'(20 + i)};
                vectors++; if (pop_data_log[i] !== exp_row || pop_last_log[i] !== (i == 5)) begin miscompares++; $display("FAIL bp_pop[%0d]: got %h last %b want %h last %b", i, pop_data_log[i], pop_last_log[i], exp_row, i == 5); end
            end
        end
        vectors++; if (rd_addr_log.size() != 6) begin miscompares++; $display("FAIL bp_rd_count: got %0d want 6", rd_addr_log.size()); end
        vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol); end
        vectors++; if (max_out > 2) begin miscompares++; $display("FAIL bp_credit: got %0d outstanding want <= 2", max_out); end
        vectors++; if (valid_cnt <= popped) begin miscompares++; $display("FAIL bp_stalled: got %0d valid cycles want > %0d", valid_cnt, popped); end
        vectors++; if (done_cyc_log.size() != 1) begin miscompares++; $display("FAIL bp_done_count: got %0d want 1", done_cyc_log.size()); end
    endtask

    task automatic test_busy_start_and_reset();
        int c0, c1; bit ok; bit bad;
        logic [RW-1:0] exp_row;
        for (int r = 0; r < 5; r++) set_row(200 + r, 2 * (r*4 + 1), 2 * (r*4 + 2), 2 * (r*4 + 3), 2 * (r*4 + 4));
        OutReady = 1'b1;
        start_job(10'd200, 11'd5, 8'd1, c0);
        @(posedge Clk); #1;
        Start = 1'b1; BaseAddr = 10'd500; NumRows = 11'd1; ShiftIn = 8'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk); #1;
            if (popped >= 2) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL busy_timeout: got %0d pops want 2", popped); end
        @(negedge Clk); #1;
        exp_row = {8'd12, 8'd11, 8'd10, 8'd9};
        vectors++; if (OutValid !== 1'b1 || OutData !== exp_row) begin miscompares++; $display("FAIL busy_row2: got valid %b data %h want valid 1 data %h", OutValid, OutData, exp_row); end
        vectors++; if (ShiftAmmount !== 8'd1) begin miscompares++; $display("FAIL busy_shift_held: got %0d want 1", ShiftAmmount); end
        bad = (rd_addr_log.size() < 3);
        for (int i = 0; i < rd_addr_log.size(); i++) if (rd_addr_log[i] !== AW'(200 + i)) bad = 1'b1;
        vectors++; if (bad) begin miscompares++; $display("FAIL busy_start_ignored: got %0d reads, first %0d want 200.. in order", rd_addr_log.size(), rd_addr_log.size() != 0 ? rd_addr_log[0] : 0); end
        #1 Rst = 1'b1;
        #1;
        vectors++; if ({Busy, Done, AccRdEn, OutValid, OutLast} !== 5'b0) begin miscompares++; $display("FAIL rst_ctrl: got %b want 00000", {Busy, Done, AccRdEn, OutValid, OutLast}); end
        vectors++; if (AccRdAddr !== '0 || ShiftAmmount !== 8'd0) begin miscompares++; $display("FAIL rst_addr_shift: got %0d/%0d want 0/0", AccRdAddr, ShiftAmmount); end
        vectors++; if (OutData !== '0) begin miscompares++; $display("FAIL rst_data: got %h want 0", OutData); end
        #1 Rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            if (OutValid !== 1'b0 || AccRdEn !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL rst_discard: got activity after abort want none"); end
        for (int r = 0; r < 3; r++) set_row(300 + r, 50 + r, 0, 0, 0);
        start_job(10'd300, 11'd3, 8'd0, c1);
        wait_done(4'b1111, c1, 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL post_rst_timeout: got no Done want Done"); end
        vectors++; if (pop_data_log.size() != 3) begin miscompares++; $display("FAIL post_rst_count: got %0d want 3", pop_data_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (pop_data_log[i] !== RW'(50 + i) || pop_last_log[i] !== (i == 2) || rd_addr_log[i] !== AW'(300 + i)) begin miscompares++; $display("FAIL post_rst_row[%0d]: got %h last %b addr %0d want %h last %b addr %0d", i, pop_data_log[i], pop_last_log[i], rd_addr_log[i], RW'(50 + i), i == 2, 300 + i); end
            end
        end
    endtask

    task automatic test_zero_rows();
        int c0;
        start_job(10'd7, 11'd0, 8'd5, c0);
        repeat (3) @(posedge Clk);
        #1;
        vectors++; if (rd_addr_log.size() != 0) begin miscompares++; $display("FAIL zero_reads: got %0d want 0", rd_addr_log.size()); end
        vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL zero_valid: got %0d valid cycles want 0", valid_cnt); end
        vectors++; if (done_cyc_log.size() != 1 || done_cyc_log[0] != c0 + 1) begin miscompares++; $display("FAIL zero_done: got %0d pulses want one at %0d", done_cyc_log.size(), c0 + 1); end
        vectors++; if (busy_cnt != 1 || busy_first != c0 + 1) begin miscompares++; $display("FAIL zero_busy: got %0d cycles from %0d want 1 at %0d", busy_cnt, busy_first, c0 + 1); end
        vectors++; if (ShiftAmmount !== 8'd5) begin miscompares++; $display("FAIL zero_shift: got %0d want 5", ShiftAmmount); end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) for (int i = 0; i < SA; i++) acc_buf[a][i] = 0;
        for (int i = 0; i < SA; i++) rd_row[i] = 0;
        clear_logs();
        test_reset();
        test_single_row();
        test_saturation();
        test_addr_wrap();
        test_backpressure();
        test_busy_start_and_reset();
        test_zero_rows();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
